mysopc_pwm_out: RTL

Avalon-MM write-side slave that turns bus register writes into a glitch-free PWM output pin. It is the output counterpart of the SOPC button input PIO: the CPU writes period, duty and control words over the same 2-bit-address, 32-bit-data slave interface, and the block drives `pwm_out` (LED or motor driver) in the SOPC fabric. Period and duty writes are double-buffered and committed only at period boundaries.

---
 rtl/mysopc_pwm_pkg.sv | 16 +
 rtl/mysopc_pwm_core.sv | 58 +++++
 rtl/mysopc_pwm_out.sv | 76 +++++++
 3 files changed

// File: rtl/mysopc_pwm_pkg.sv
// Shared constants for the mysopc PWM output slave: register map and CTRL bit layout.
package mysopc_pwm_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ADDR_CTRL   = 2'd0,
    ADDR_PERIOD = 2'd1,
    ADDR_DUTY   = 2'd2,
    ADDR_COUNT  = 2'd3
  } addr_e;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_POL = 1;

endpackage

// File: rtl/mysopc_pwm_core.sv
// PWM engine: period counter, active period/duty copies committed at wrap, registered output.
module mysopc_pwm_core
  import mysopc_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             pol,
  input  logic [CNT_W-1:0] per_sh,
  input  logic [CNT_W-1:0] duty_sh,
  output logic             pwm_out,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] per_act;
  logic [CNT_W-1:0] duty_act;
  logic             idle;
  logic             wrap;
  logic [CNT_W-1:0] last;

  always_comb begin
    idle = 1'b0;
    last = '0;
    wrap = 1'b0;
    idle = ~en | (per_act == '0);
    last = per_act - ONE;
    wrap = (cnt == last);
  end

  // Idle keeps the active copies tracking the shadows so enabling starts from fresh values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      per_act  <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else if (idle) begin
      cnt      <= '0;
      per_act  <= per_sh;
      duty_act <= duty_sh;
      pwm_out  <= pol;
    end else begin
      pwm_out <= (cnt < duty_act) ^ pol;
      if (wrap) begin
        cnt      <= '0;
        per_act  <= per_sh;
        duty_act <= duty_sh;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/mysopc_pwm_out.sv
// Avalon-MM PWM output slave: CTRL/PERIOD/DUTY registers, COUNT readback, double-buffered PWM.
// Optional readback mux built only when MYSOPC_PWM_READBACK_EN is defined.
module mysopc_pwm_out
  import mysopc_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pwm_out
);

  logic             wr;
  logic             ctrl_en;
  logic             ctrl_pol;
  logic [CNT_W-1:0] per_sh;
  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] cnt;
  logic             unused_bits;

  assign wr          = chipselect & ~write_n;
  assign unused_bits = &{1'b0, writedata, cnt};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en  <= 1'b0;
      ctrl_pol <= 1'b0;
      per_sh   <= '0;
      duty_sh  <= '0;
    end else if (wr) begin
      case (addr_e'(address))
        ADDR_CTRL: begin
          ctrl_en  <= writedata[CTRL_EN];
          ctrl_pol <= writedata[CTRL_POL];
        end
        ADDR_PERIOD: per_sh  <= writedata[CNT_W-1:0];
        ADDR_DUTY:   duty_sh <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  mysopc_pwm_core #(.CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ctrl_en),
    .pol     (ctrl_pol),
    .per_sh  (per_sh),
    .duty_sh (duty_sh),
    .pwm_out (pwm_out),
    .cnt     (cnt)
  );

`ifdef MYSOPC_PWM_READBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (addr_e'(address))
        ADDR_CTRL:   readdata <= {30'b0, ctrl_pol, ctrl_en};
        ADDR_PERIOD: readdata <= 32'(per_sh);
        ADDR_DUTY:   readdata <= 32'(duty_sh);
        default:     readdata <= 32'(cnt);
      endcase
    end
  end
`else
  assign readdata = '0;
`endif

endmodule
